// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider bank: FSM states and per-channel config payload.
package clk_div_pkg;

  // Widest divisor/phase field carried on the config bus; DIV_W must not exceed it.
  localparam int unsigned CFG_W = 16;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel: holds div/phase, counts 0..div-1, emits registered tick and sq.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic    refclk,
  input  logic    rst_n,
  input  logic    i_run,
  input  logic    i_wr,
  input  logic    i_realign,
  input  ch_cfg_t i_cfg,
  output logic    o_tick,
  output logic    o_sq
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_phase_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_half;
  logic             w_tick_nxt;
  logic             w_sq_nxt;

  // tick/sq are derived from the next count and divisor so they always match cnt/div_r
  always_comb begin
    w_div_nxt   = i_wr ? DIV_W'(i_cfg.div) : r_div;
    w_phase_nxt = i_wr ? DIV_W'(i_cfg.phase) : r_phase;
    w_half      = DIV_W'(({1'b0, w_div_nxt} + (DIV_W+1)'(1)) >> 1);
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = o_tick;
    w_sq_nxt    = o_sq;
    if (i_run) begin
      if (w_div_nxt == '0) begin
        w_cnt_nxt = '0;
      end else if (i_realign) begin
        w_cnt_nxt = (w_phase_nxt < w_div_nxt) ? w_phase_nxt : '0;
      end else if (r_cnt >= w_div_nxt - DIV_W'(1)) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
      w_tick_nxt = (w_div_nxt != '0) && (w_cnt_nxt == w_div_nxt - DIV_W'(1));
      w_sq_nxt   = (w_div_nxt != '0) && (w_cnt_nxt < w_half);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= DIV_W'(DEFAULT_DIV);
      r_phase <= '0;
      r_cnt   <= '0;
      o_tick  <= 1'b0;
      o_sq    <= 1'b0;
    end else begin
      r_div   <= w_div_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      o_tick  <= w_tick_nxt;
      o_sq    <= w_sq_nxt;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of phase-alignable clock-enable dividers with config handshake and lock indication.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);

  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_rst_n;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_nxt;
  logic              r_realign;
  logic              w_realign_nxt;
  logic              w_ch_ok;
  logic              w_acc;
  logic [NUM_CH-1:0] w_wr;
  ch_cfg_t           w_cfg;

  // Assertion is immediate; release is delayed two refclk edges.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= 1'b1;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rst_n = r_sync2;

  assign w_ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  assign w_acc       = cfg_valid && cfg_ready && w_ch_ok;
  assign w_cfg.div   = CFG_W'(cfg_div);
  assign w_cfg.phase = CFG_W'(cfg_phase);

  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_INIT;
      r_lock_cnt <= '0;
      r_realign  <= 1'b0;
      cfg_ready  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_realign  <= w_realign_nxt;
      cfg_ready  <= (w_state_nxt != ST_INIT);
      locked     <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Any accepted valid write restarts alignment, even mid-ALIGN.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_nxt    = r_lock_cnt;
    w_realign_nxt = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_state_nxt   = ST_ALIGN;
        w_lock_nxt    = '0;
        w_realign_nxt = 1'b1;
      end
      ST_ALIGN: begin
        if (w_acc) begin
          w_lock_nxt    = '0;
          w_realign_nxt = 1'b1;
        end else if (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_lock_nxt = r_lock_cnt + LOCK_W'(1);
        end
      end
      ST_LOCKED: begin
        if (w_acc) begin
          w_state_nxt   = ST_ALIGN;
          w_lock_nxt    = '0;
          w_realign_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_lock_nxt  = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = w_acc && (cfg_ch == CH_W'(i));

    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .refclk    (refclk),
      .rst_n     (w_rst_n),
      .i_run     (r_state != ST_INIT),
      .i_wr      (w_wr[i]),
      .i_realign (r_realign),
      .i_cfg     (w_cfg),
      .o_tick    (tick[i]),
      .o_sq      (sq[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a cycle-level reference model and literal anchors.
module tb_clk_div_bank;

  localparam int NCH  = 3;
  localparam int LOCK = 16;

  logic           refclk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [15:0]    cfg_div = '0;
  logic [15:0]    cfg_phase = '0;
  logic           cfg_ready;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic           locked;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(
    .NUM_CH      (NCH),
    .DIV_W       (16),
    .DEFAULT_DIV (2),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .tick      (tick),
    .sq        (sq),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=init 1=align 2=locked; channel count = (start + elapsed) mod div
  int m_sync = 0, m_mode = 0, m_lockc = 0, cyc = 0;
  bit m_pending = 0, m_aligned = 0, m_ready = 0, m_locked = 0;
  int m_div[NCH], m_phase[NCH], m_start[NCH], m_t0[NCH];

  always @(posedge refclk or negedge rst) begin
    bit acc;
    if (!rst) begin
      m_sync = 0; m_mode = 0; m_lockc = 0;
      m_pending = 0; m_aligned = 0; m_ready = 0; m_locked = 0;
      for (int c = 0; c < NCH; c++) begin m_div[c] = 2; m_phase[c] = 0; end
    end else begin
      cyc++;
      if (m_sync < 2) begin
        m_sync++;
      end else begin
        acc = m_ready && cfg_valid && (int'(cfg_ch) < NCH);
        if (m_pending) begin
          for (int c = 0; c < NCH; c++) begin
            m_start[c] = (m_phase[c] < m_div[c]) ? m_phase[c] : 0;
            m_t0[c] = cyc;
          end
          m_aligned = 1;
          m_pending = 0;
        end
        if (m_mode == 0) begin
          m_mode = 1; m_lockc = 0; m_pending = 1;
        end else if (acc) begin
          m_div[cfg_ch] = int'(cfg_div);
          m_phase[cfg_ch] = int'(cfg_phase);
          m_mode = 1; m_lockc = 0; m_pending = 1;
        end else if (m_mode == 1) begin
          if (m_lockc == LOCK - 1) m_mode = 2;
          else m_lockc++;
        end
      end
      m_ready = (m_mode != 0);
      m_locked = (m_mode == 2);
    end
  end

  always @(negedge refclk) begin
    int cnt;
    bit et, es;
    chk("cfg_ready", cfg_ready, m_ready);
    chk("locked", locked, m_locked);
    for (int c = 0; c < NCH; c++) begin
      if (m_aligned && m_pending) continue;
      et = 0; es = 0;
      if (m_aligned && m_div[c] != 0) begin
        cnt = (m_start[c] + (cyc - m_t0[c])) % m_div[c];
        et = (cnt == m_div[c] - 1);
        es = (cnt < (m_div[c] + 1) / 2);
      end
      chk($sformatf("tick[%0d]", c), tick[c], et);
      chk($sformatf("sq[%0d]", c), sq[c], es);
    end
  end

  task automatic wr(input int ch, input int dv, input int ph);
    @(negedge refclk);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 16'(dv); cfg_phase = 16'(ph);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!cfg_ready && n < 50) begin @(negedge refclk); n++; end
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (!locked && n < 100) begin @(negedge refclk); n++; end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge refclk);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_locked", locked, 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_sq", 32'(sq), 0);

    // reset release with defaults
    rst = 1'b1;
    wait_ready(n);
    chk("ready_latency", n, 3);
    wait_locked(n);
    chk("lock_latency", n, 16);
    for (int k = 0; k < 4; k++) begin
      chk("tick_alt", tick[0], (k % 2 == 0) ? 1 : 0);
      @(negedge refclk);
    end

    // div 5 with a 2-cycle phase lead on ch1
    wr(0, 5, 0);
    chk("locked_drop", locked, 0);
    wr(1, 5, 2);
    n = 0;
    while (!tick[1] && n < 10) begin @(negedge refclk); n++; end
    n = 0;
    do begin @(negedge refclk); n++; end while (!tick[0] && n < 10);
    chk("tick_lead", n, 2);
    n = 0;
    for (int k = 0; k < 5; k++) begin @(negedge refclk); n += int'(sq[0]); end
    chk("sq_duty5", n, 3);
    wait_locked(n);
    chk("lock_after_wr", locked, 1);

    // phase clamp, then a second write at lock count 10
    wr(0, 4, 0);
    wr(1, 4, 7);
    for (int k = 1; k <= 8; k++) begin
      @(negedge refclk);
      chk("clamp_tick0", tick[0], (k % 4 == 0) ? 1 : 0);
      chk("clamp_tick1", tick[1], (k % 4 == 0) ? 1 : 0);
    end
    @(negedge refclk);
    chk("align_unlocked", locked, 0);
    wr(0, 4, 0);
    wait_locked(n);
    chk("relock_latency", n, 16);

    // disabled and div-1 channels
    wr(0, 0, 0);
    repeat (2) @(negedge refclk);
    for (int k = 0; k < 4; k++) begin
      chk("div0_tick", tick[0], 0);
      chk("div0_sq", sq[0], 0);
      @(negedge refclk);
    end
    wr(0, 1, 0);
    repeat (2) @(negedge refclk);
    for (int k = 0; k < 4; k++) begin
      chk("div1_tick", tick[0], 1);
      chk("div1_sq", sq[0], 1);
      @(negedge refclk);
    end

    // out-of-range channel write is ignored
    wait_locked(n);
    wr(3, 9, 9);
    for (int k = 0; k < 20; k++) begin
      chk("badch_locked", locked, 1);
      @(negedge refclk);
    end

    // mid-period reset clears everything immediately
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_sq", 32'(sq), 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    repeat (3) @(negedge refclk);
    rst = 1'b1;
    wait_ready(n);
    chk("ready_latency2", n, 3);
    wait_locked(n);
    chk("lock_latency2", n, 16);
    repeat (6) @(negedge refclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
